// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared FSM encoding, counter sizing and MEM/WB bundle type for
//            the memory-access pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Sized for the largest legal timeout so any TIMEOUT_CYCLES fits.
    localparam int unsigned TIMEOUT_MAX = 255;
    localparam int unsigned CNT_W       = $clog2(TIMEOUT_MAX + 1);

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [4:0]  write_reg;
    } wb_bundle_t;

    function automatic wb_bundle_t wb_bubble();
        wb_bubble = '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_timeout_ctr
// Purpose  : Clear/enable WAIT-cycle counter; tc_o flags the final allowed
//            WAIT cycle of an access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int unsigned LIMIT = 16
)
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] c_TERMINAL = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Counter holds k-1 during the k-th WAIT cycle.
    assign tc_o = en_i && (cnt_q == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage: handshaked loads/stores, branch resolve and
//            the MEM/WB register. Option: MEM_STAGE_ALIGN_CHECK_EN rejects
//            word-misaligned accesses without issuing a request.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              zero,
    input  logic [31:0]       ALUOut,
    input  logic [31:0]       WriteData,
    input  logic [31:0]       PCBranch,
    input  logic [4:0]        WriteReg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              PCSrc,
    output logic [31:0]       PCBranchOut,
    output logic              Stall,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [31:0]       wb_ReadData,
    output logic [31:0]       wb_ALUOut,
    output logic [4:0]        wb_WriteReg,
    output logic              ErrFlag
);

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              abort_q, abort_d;
    logic              err_q, err_d;
    wb_bundle_t        wb_q, wb_d;

    logic w_mem_op;
    logic w_misaligned;
    logic w_launch;
    logic w_tc;

    assign w_mem_op = MemtoReg | MemWrite;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign w_misaligned = (ALUOut[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (w_launch),
        .en_i  (state_q == ST_WAIT),
        .tc_o  (w_tc)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        abort_d  = abort_q;
        err_d    = err_q;
        wb_d     = wb_bubble();
        w_launch = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_mem_op) begin
                    if (w_misaligned) begin
                        state_d = ST_DONE;
                        abort_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = ST_WAIT;
                        req_d    = 1'b1;
                        we_d     = MemWrite;
                        addr_d   = ALUOut[ADDR_W-1:0];
                        wdata_d  = WriteData;
                        abort_d  = 1'b0;
                        w_launch = 1'b1;
                    end
                end else begin
                    wb_d.reg_write = RegWrite;
                    wb_d.alu_out   = ALUOut;
                    wb_d.write_reg = WriteReg;
                end
            end
            ST_WAIT: begin
                // Ready wins over a simultaneous terminal count.
                if (dmem_ready) begin
                    rdata_d = dmem_rdata;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (w_tc) begin
                    req_d   = 1'b0;
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_d.reg_write  = RegWrite & ~abort_q;
                wb_d.mem_to_reg = MemtoReg;
                wb_d.read_data  = (MemtoReg & ~abort_q) ? rdata_q : 32'd0;
                wb_d.alu_out    = ALUOut;
                wb_d.write_reg  = WriteReg;
                abort_d         = 1'b0;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            wb_q    <= wb_bubble();
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            wb_q    <= wb_d;
        end
    end

    assign Stall       = ((state_q == ST_IDLE) & w_mem_op) | (state_q == ST_WAIT);
    assign PCSrc       = Branch & zero & ~Stall;
    assign PCBranchOut = PCBranch;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign ErrFlag     = err_q;
    assign wb_RegWrite = wb_q.reg_write;
    assign wb_MemtoReg = wb_q.mem_to_reg;
    assign wb_ReadData = wb_q.read_data;
    assign wb_ALUOut   = wb_q.alu_out;
    assign wb_WriteReg = wb_q.write_reg;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage (TIMEOUT_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RegWrite, MemtoReg, MemWrite, Branch, zero;
    logic [31:0] ALUOut, WriteData, PCBranch;
    logic [4:0]  WriteReg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        PCSrc;
    logic [31:0] PCBranchOut;
    logic        Stall;
    logic        wb_RegWrite, wb_MemtoReg;
    logic [31:0] wb_ReadData, wb_ALUOut;
    logic [4:0]  wb_WriteReg;
    logic        ErrFlag;

    int errors = 0;
    int checks = 0;
    logic exp_err = 1'b0;

    always #5 CLK = ~CLK;

    mem_stage #(
        .TIMEOUT_CYCLES (TMO),
        .ADDR_W         (32)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .MemWrite    (MemWrite),
        .Branch      (Branch),
        .zero        (zero),
        .ALUOut      (ALUOut),
        .WriteData   (WriteData),
        .PCBranch    (PCBranch),
        .WriteReg    (WriteReg),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .PCSrc       (PCSrc),
        .PCBranchOut (PCBranchOut),
        .Stall       (Stall),
        .wb_RegWrite (wb_RegWrite),
        .wb_MemtoReg (wb_MemtoReg),
        .wb_ReadData (wb_ReadData),
        .wb_ALUOut   (wb_ALUOut),
        .wb_WriteReg (wb_WriteReg),
        .ErrFlag     (ErrFlag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mtr, input logic mw, input logic br,
                         input logic z, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pcb, input logic [4:0] wr);
        RegWrite = rw; MemtoReg = mtr; MemWrite = mw; Branch = br; zero = z;
        ALUOut = alu; WriteData = wd; PCBranch = pcb; WriteReg = wr;
    endtask

    // ready_at: WAIT cycle (1-based) in which memory answers; 0 = never.
    task automatic run_instr(input logic rw, input logic mtr, input logic mw, input logic br,
                             input logic z, input logic [31:0] alu, input logic [31:0] wd,
                             input logic [31:0] pcb, input logic [4:0] wr,
                             input int ready_at, input logic [31:0] rdata);
        int   waits;
        int   stalls;
        int   exp_waits;
        logic abort;
        drive(rw, mtr, mw, br, z, alu, wd, pcb, wr);
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        #1;
        if (!(mtr | mw)) begin
            chk("alu_stall", 32'(Stall), 32'd0);
            chk("pcsrc", 32'(PCSrc), 32'(br & z));
            chk("pcbranchout", PCBranchOut, pcb);
            step();
            chk("alu_wb_regwrite", 32'(wb_RegWrite), 32'(rw));
            chk("alu_wb_memtoreg", 32'(wb_MemtoReg), 32'd0);
            chk("alu_wb_aluout", wb_ALUOut, alu);
            chk("alu_wb_writereg", 32'(wb_WriteReg), 32'(wr));
            chk("alu_wb_readdata", wb_ReadData, 32'd0);
            return;
        end
        dmem_ready = 1'b0;
        #1;
        exp_waits = (ready_at >= 1 && ready_at <= TMO) ? ready_at : TMO;
        abort     = (exp_waits != ready_at);
        stalls    = 0;
        chk("issue_stall", 32'(Stall), 32'd1);
        chk("issue_req", 32'(dmem_req), 32'd0);
        chk("issue_pcsrc", 32'(PCSrc), 32'd0);
        stalls += int'(Stall);
        step();
        for (waits = 1; waits <= exp_waits; waits++) begin
            chk("wait_req", 32'(dmem_req), 32'd1);
            chk("wait_we", 32'(dmem_we), 32'(mw));
            chk("wait_addr", dmem_addr, alu);
            chk("wait_wdata", dmem_wdata, wd);
            chk("bubble_regwrite", 32'(wb_RegWrite), 32'd0);
            chk("bubble_memtoreg", 32'(wb_MemtoReg), 32'd0);
            stalls += int'(Stall);
            if (waits == ready_at) begin
                dmem_ready = 1'b1;
                dmem_rdata = rdata;
            end
            step();
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
        end
        if (abort) exp_err = 1'b1;
        #1;
        chk("stall_cycles", 32'(stalls), 32'(1 + exp_waits));
        chk("done_stall", 32'(Stall), 32'd0);
        chk("done_req", 32'(dmem_req), 32'd0);
        chk("done_bubble", 32'(wb_RegWrite), 32'd0);
        chk("errflag", 32'(ErrFlag), 32'(exp_err));
        step();
        chk("mem_wb_regwrite", 32'(wb_RegWrite), 32'(rw & ~abort));
        chk("mem_wb_memtoreg", 32'(wb_MemtoReg), 32'(mtr));
        chk("mem_wb_aluout", wb_ALUOut, alu);
        chk("mem_wb_writereg", 32'(wb_WriteReg), 32'(wr));
        if (!abort) chk("mem_wb_readdata", wb_ReadData, mtr ? rdata : 32'd0);
        chk("errflag_sticky", 32'(ErrFlag), 32'(exp_err));
    endtask

    initial begin
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        step();
        step();
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wb", {wb_RegWrite, wb_MemtoReg, wb_WriteReg}, 32'd0);
        chk("rst_wb_data", wb_ReadData | wb_ALUOut, 32'd0);
        chk("rst_err", 32'(ErrFlag), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        RST = 1'b0;

        // ALU op, branch taken / not taken.
        run_instr(1, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0, 5'd5, 0, 32'h0);
        run_instr(0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h200, 5'd0, 0, 32'h0);
        run_instr(0, 0, 0, 1, 0, 32'h4, 32'h0, 32'h300, 5'd0, 0, 32'h0);
        // Load 0x40 with ready on 3rd WAIT cycle, store 0x1234 to 0x80.
        run_instr(1, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 5'd7, 3, 32'hDEADBEEF);
        run_instr(0, 0, 1, 0, 0, 32'h80, 32'h1234, 32'h0, 5'd0, 1, 32'hCAFEF00D);
        // Ready in the same cycle as the terminal count still succeeds.
        run_instr(1, 1, 0, 0, 0, 32'h84, 32'h0, 32'h0, 5'd9, TMO, 32'h13572468);

        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: run_instr(1'($urandom), 0, 0, 0, 0, $urandom, $urandom, $urandom,
                             5'($urandom), 0, 32'h0);
                1: run_instr(0, 0, 0, 1, 1'($urandom), $urandom, $urandom, $urandom,
                             5'($urandom), 0, 32'h0);
                2: run_instr(1, 1, 0, 0, 0, $urandom, $urandom, $urandom, 5'($urandom),
                             int'($urandom_range(1, TMO)), $urandom);
                default: run_instr(0, 0, 1, 0, 0, $urandom, $urandom, $urandom,
                                   5'($urandom), int'($urandom_range(1, TMO)), $urandom);
            endcase
        end

        // Timeout: memory never answers.
        run_instr(1, 1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 5'd3, 0, 32'h0);
        run_instr(1, 0, 0, 0, 0, 32'h55, 32'h0, 32'h0, 5'd4, 0, 32'h0);
        chk("err_still_set", 32'(ErrFlag), 32'd1);

        // Reset in the second WAIT cycle abandons the access.
        drive(1, 1, 0, 0, 0, 32'h44, 32'h0, 32'h0, 5'd6);
        dmem_ready = 1'b0;
        step();
        step();
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        RST = 1'b0;
        #1;
        chk("rstw_req", 32'(dmem_req), 32'd0);
        chk("rstw_stall", 32'(Stall), 32'd0);
        chk("rstw_wb", {wb_RegWrite, wb_MemtoReg, wb_WriteReg}, 32'd0);
        chk("rstw_wb_data", wb_ReadData | wb_ALUOut, 32'd0);
        chk("rstw_err", 32'(ErrFlag), 32'd0);
        exp_err = 1'b0;
        run_instr(1, 0, 0, 0, 0, 32'h77, 32'h0, 32'h0, 5'd2, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
